// File: rtl/mem_access_ctrl_if.sv
// Purpose : request/response and RAM-side signal bundle for mem_access_ctrl.
// Latency : n/a (wires only).
// Backpressure: req_valid/req_ready handshake; the RAM side has no backpressure.
// Ports   : master = datapath + RAM side (drives requests and mem_rdata),
//           slave  = controller (drives req_ready, resp_* and mem_* outputs).
interface mem_access_ctrl_if #(
   parameter int AW = 32
);
   logic          req_valid;
   logic          req_ready;
   logic          req_store;
   logic [1:0]    req_size;
   logic          req_unsigned;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          resp_err;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_wen;
   logic [1:0]    mem_sel;
   logic [31:0]   mem_rdata;

   modport master (
      output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_wen, mem_sel
   );

   modport slave (
      input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_wen, mem_sel
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Purpose : single-outstanding load/store controller for a byte-addressed little-endian RAM,
//           with alignment checking and byte/half sign/zero extension of load data.
// Latency : good request responds WAIT_CYCLES+1 cycles after accept; error request after 1.
// Backpressure: req_ready is high only in IDLE; one request per WAIT_CYCLES+2 cycles at best.
// Ports   : CLK, RST (async active-high) and bus (slave modport of mem_access_ctrl_if).
module mem_access_ctrl #(
   parameter int WAIT_CYCLES = 1,
   parameter int AW          = 32
) (
   input logic              CLK,
   input logic              RST,
   mem_access_ctrl_if.slave bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          store_q, store_d;
   logic [1:0]    size_q, size_d;
   logic          uns_q, uns_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;

   logic          req_err;
   logic [31:0]   load_ext;

   // Reserved size, or word/half not naturally aligned. Bytes are always aligned.
   assign req_err = (bus.req_size == 2'b11) ||
                    ((bus.req_size == 2'b00) && (bus.req_addr[1:0] != 2'b00)) ||
                    ((bus.req_size == 2'b01) && bus.req_addr[0]);

   // The RAM presents the addressed byte in bits [7:0], so extraction never shifts.
   always_comb begin
      load_ext = bus.mem_rdata;
      case (size_q)
         2'b01:   load_ext = {{16{~uns_q & bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
         2'b10:   load_ext = {{24{~uns_q & bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
         default: load_ext = bus.mem_rdata;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      store_d = store_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               store_d = bus.req_store;
               size_d  = bus.req_size;
               uns_d   = bus.req_unsigned;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               if (req_err) begin
                  // Response fields settle on entry to RESP and hold until the next one.
                  state_d = ST_RESP;
                  err_d   = 1'b1;
                  rdata_d = 32'd0;
               end else begin
                  state_d = ST_ACCESS;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         ST_ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_RESP;
               err_d   = 1'b0;
               rdata_d = store_q ? 32'd0 : load_ext;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         store_q <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         store_q <= store_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign bus.req_ready  = (state_q == ST_IDLE);
   assign bus.resp_valid = (state_q == ST_RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_wdata  = wdata_q;
   assign bus.mem_sel    = size_q;
   // Write strobe only on the final ACCESS cycle; errors never reach ACCESS.
   assign bus.mem_wen    = (state_q == ST_ACCESS) && (cnt_q == 4'd0) && store_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
   localparam int WA = 1;
   localparam int WB = 3;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acc;
      int          wen;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   stray = 0;
   int   wen_seen = 0;

   exp_t sb_q[$];
   exp_t mon_e;

   logic [7:0] ram [256];
   logic [7:0] ref_mem [256];
   logic       ram_load = 1'b0;

   logic        sel = 1'b0;
   logic        drv_valid = 1'b0;
   logic        drv_store = 1'b0;
   logic [1:0]  drv_size = 2'b00;
   logic        drv_uns = 1'b0;
   logic [31:0] drv_addr = 32'd0;
   logic [31:0] drv_wdata = 32'd0;

   mem_access_ctrl_if #(.AW(32)) if_a ();
   mem_access_ctrl_if #(.AW(32)) if_b ();

   mem_access_ctrl #(.WAIT_CYCLES(WA), .AW(32)) dut_a (.CLK(CLK), .RST(RST), .bus(if_a));
   mem_access_ctrl #(.WAIT_CYCLES(WB), .AW(32)) dut_b (.CLK(CLK), .RST(RST), .bus(if_b));

   initial forever #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   assign if_a.req_valid    = drv_valid & ~sel;
   assign if_b.req_valid    = drv_valid & sel;
   assign if_a.req_store    = drv_store;
   assign if_b.req_store    = drv_store;
   assign if_a.req_size     = drv_size;
   assign if_b.req_size     = drv_size;
   assign if_a.req_unsigned = drv_uns;
   assign if_b.req_unsigned = drv_uns;
   assign if_a.req_addr     = drv_addr;
   assign if_b.req_addr     = drv_addr;
   assign if_a.req_wdata    = drv_wdata;
   assign if_b.req_wdata    = drv_wdata;

   // Behavioural RAM: returns the little-endian word starting at mem_addr (256-byte wrap).
   always_comb if_a.mem_rdata = {ram[if_a.mem_addr[7:0] + 8'd3], ram[if_a.mem_addr[7:0] + 8'd2],
                                 ram[if_a.mem_addr[7:0] + 8'd1], ram[if_a.mem_addr[7:0]]};
   always_comb if_b.mem_rdata = {ram[if_b.mem_addr[7:0] + 8'd3], ram[if_b.mem_addr[7:0] + 8'd2],
                                 ram[if_b.mem_addr[7:0] + 8'd1], ram[if_b.mem_addr[7:0]]};

   logic        cur_ready, cur_rvalid, cur_err, cur_wen, oth_rvalid, oth_wen;
   logic [31:0] cur_rdata, cur_maddr, cur_mwdata;
   logic [1:0]  cur_msel;
   assign cur_ready  = sel ? if_b.req_ready  : if_a.req_ready;
   assign cur_rvalid = sel ? if_b.resp_valid : if_a.resp_valid;
   assign cur_err    = sel ? if_b.resp_err   : if_a.resp_err;
   assign cur_rdata  = sel ? if_b.resp_rdata : if_a.resp_rdata;
   assign cur_wen    = sel ? if_b.mem_wen    : if_a.mem_wen;
   assign cur_maddr  = sel ? if_b.mem_addr   : if_a.mem_addr;
   assign cur_mwdata = sel ? if_b.mem_wdata  : if_a.mem_wdata;
   assign cur_msel   = sel ? if_b.mem_sel    : if_a.mem_sel;
   assign oth_rvalid = sel ? if_a.resp_valid : if_b.resp_valid;
   assign oth_wen    = sel ? if_a.mem_wen    : if_b.mem_wen;

   always @(posedge CLK) begin
      if (ram_load) begin
         for (int i = 0; i < 256; i++) ram[i] <= ref_mem[i];
      end else if (cur_wen) begin
         ram[cur_maddr[7:0]] <= cur_mwdata[7:0];
         if (cur_msel != 2'b10) ram[cur_maddr[7:0] + 8'd1] <= cur_mwdata[15:8];
         if (cur_msel == 2'b00) begin
            ram[cur_maddr[7:0] + 8'd2] <= cur_mwdata[23:16];
            ram[cur_maddr[7:0] + 8'd3] <= cur_mwdata[31:24];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every response, checks RAM-side activity in between.
   always @(negedge CLK) begin
      if (RST) begin
         wen_seen = 0;
      end else begin
         if (oth_rvalid || oth_wen) stray++;
         if (cur_wen) begin
            if (sb_q.size() == 0) stray++;
            else begin
               wen_seen++;
               chk("store mem_wdata", cur_mwdata, sb_q[0].wdata);
            end
         end
         if (sb_q.size() > 0 && !sb_q[0].err && cyc >= sb_q[0].acc && cyc < sb_q[0].acc + sb_q[0].lat - 1) begin
            chk("mem_addr during access", cur_maddr, sb_q[0].addr);
            chk("mem_sel during access", {30'd0, cur_msel}, {30'd0, sb_q[0].size});
         end
         if (cur_rvalid) begin
            if (sb_q.size() == 0) begin
               chk("unexpected resp_valid", 32'd1, 32'd0);
            end else begin
               mon_e = sb_q.pop_front();
               chk("resp_rdata", cur_rdata, mon_e.rdata);
               chk("resp_err", {31'd0, cur_err}, {31'd0, mon_e.err});
               chk("resp latency", 32'(cyc + 1 - mon_e.acc), 32'(mon_e.lat));
               chk("mem_wen pulses", 32'(wen_seen), 32'(mon_e.wen));
               wen_seen = 0;
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic issue(input logic st, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                        input logic [31:0] wd, input bit keep, input bit expect_resp, output int acc);
      exp_t        e;
      int          nb;
      int          n;
      logic [63:0] v;
      drv_store = st; drv_size = sz; drv_uns = uns; drv_addr = addr; drv_wdata = wd;
      drv_valid = 1'b1;
      n = 0;
      while (!cur_ready && n < 100) begin
         @(negedge CLK);
         n++;
      end
      chk("request accepted", {31'd0, cur_ready}, 32'd1);
      if (!cur_ready) begin
         drv_valid = 1'b0;
         acc = -1;
         return;
      end
      acc = cyc + 1;
      if (expect_resp) begin
         nb = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
         e.err = (sz == 2'd3) || ((int'(addr[1:0]) % nb) != 0);
         v = 64'd0;
         if (!e.err && !st) begin
            for (int k = 0; k < nb; k++) v = v | (64'(ref_mem[(int'(addr[7:0]) + k) % 256]) << (8 * k));
            if (!uns && nb < 4 && v[nb * 8 - 1]) v = v - (64'd1 << (nb * 8));
         end
         if (!e.err && st) begin
            for (int k = 0; k < nb; k++) ref_mem[(int'(addr[7:0]) + k) % 256] = 8'(wd >> (8 * k));
         end
         e.rdata = (st || e.err) ? 32'd0 : v[31:0];
         e.lat   = e.err ? 1 : (sel ? WB : WA) + 1;
         e.acc   = acc;
         e.wen   = (st && !e.err) ? 1 : 0;
         e.size  = sz;
         e.addr  = addr;
         e.wdata = wd;
         sb_q.push_back(e);
      end
      @(negedge CLK);
      if (!keep) drv_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() > 0 && n < 200) begin
         @(negedge CLK);
         n++;
      end
      chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
      repeat (2) @(negedge CLK);
   endtask

   task automatic random_burst(input int cnt);
      int          acc;
      logic [31:0] a;
      logic [1:0]  sz;
      for (int i = 0; i < cnt; i++) begin
         sz = 2'($urandom_range(0, 3));
         a  = $urandom();
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom(), 1'b0, 1'b1, acc);
         repeat ($urandom_range(0, 2)) @(negedge CLK);
      end
   endtask

   initial begin
      int acc1, acc2;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom_range(0, 255));
      ram_load = 1'b1;
      repeat (3) @(negedge CLK);
      ram_load = 1'b0;
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         #1;
         chk("reset req_ready", {31'd0, cur_ready}, 32'd1);
         chk("reset resp_valid", {31'd0, cur_rvalid}, 32'd0);
         chk("reset resp_rdata", cur_rdata, 32'd0);
         chk("reset resp_err", {31'd0, cur_err}, 32'd0);
         chk("reset mem_addr", cur_maddr, 32'd0);
         chk("reset mem_wdata", cur_mwdata, 32'd0);
         chk("reset mem_wen", {31'd0, cur_wen}, 32'd0);
         chk("reset mem_sel", {30'd0, cur_msel}, 32'd0);
      end
      sel = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);

      // Short-wait instance: store word, byte loads, error requests, random traffic.
      issue(1'b1, 2'b00, 1'b0, 32'h10, 32'hA1B2C3D4, 1'b0, 1'b1, acc1);
      issue(1'b1, 2'b00, 1'b0, 32'h10, 32'h000000F0, 1'b0, 1'b1, acc1);
      issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, acc1);
      issue(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 1'b0, 1'b1, acc1);
      drain();
      chk("ram word at 0x10", {ram[8'h13], ram[8'h12], ram[8'h11], ram[8'h10]}, 32'h000000F0);
      issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 1'b1, acc1);
      issue(1'b1, 2'b01, 1'b0, 32'h11, 32'h5555AAAA, 1'b0, 1'b1, acc1);
      issue(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, acc1);
      random_burst(40);
      drain();

      // Longer-wait instance: half load, back-to-back with request fields changing mid-access.
      sel = 1'b1;
      @(negedge CLK);
      issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h12348001, 1'b0, 1'b1, acc1);
      issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 1'b1, acc1);
      drain();
      issue(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, acc1);
      issue(1'b0, 2'b00, 1'b0, 32'h24, 32'h0, 1'b0, 1'b1, acc2);
      chk("back-to-back accept spacing", 32'(acc2 - acc1), 32'(WB + 2));
      random_burst(40);
      drain();

      // Reset during the first ACCESS cycle of a store: no write, no response.
      issue(1'b1, 2'b00, 1'b0, 32'h30, 32'hDEADBEEF, 1'b0, 1'b0, acc1);
      RST = 1'b1;
      #1;
      chk("mid-reset mem_wen", {31'd0, cur_wen}, 32'd0);
      chk("mid-reset resp_valid", {31'd0, cur_rvalid}, 32'd0);
      chk("mid-reset req_ready", {31'd0, cur_ready}, 32'd1);
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      issue(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 1'b0, 1'b1, acc1);
      drain();

      chk("stray resp or write count", 32'(stray), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1, "timeout");
   end
endmodule
